fd_reg: RTL and testbench
=========================

// Module: fd_reg
// PURPOSE
//  F->D pipeline register of the 5-stage MIPS core; sits directly downstream of the PC/fetch stage.
//  Captures pc_F and instr_F each cycle and presents pc_D, instr_D and pre-sliced decode fields to D.
//  Handles hold on stall and bubble insertion on flush.
//  Tracks the branch-delay-slot flag and a saturating stall-cycle counter.
// PARAMETERS
//  RESET_PC     32'h0000_3000  value loaded into pc_D on reset
//  PC_LO        32'h0000_3000  lowest legal fetch address (used only under FD_ALIGN_CHECK_EN)
//  PC_HI        32'h0000_6FFC  highest legal fetch address (used only under FD_ALIGN_CHECK_EN)
//  CNT_W        16             width of stall_cnt
// PORTS
//  clk          in   1      rising-edge clock, single clock domain
//  reset        in   1      synchronous, active-high
//  stall        in   1      hazard-unit stall; hold D contents
//  flush        in   1      replace D contents with bubble
//  pc_F         in   32     PC of instruction in F
//  instr_F      in   32     IM read data for pc_F
//  jump_D       in   1      decoder: current instr_D is branch/jump (beq/bne/jal/jr/...)
//  pc_D         out  32     PC of instruction in D
//  instr_D      out  32     instruction in D (32'h0 = nop bubble)
//  valid_D      out  1      instr_D is a real fetched instruction
//  bd_D         out  1      instr_D sits in a branch delay slot
//  exc_D        out  5      fetch exception code (0 = none)
//  op_D         out  6      instr_D[31:26]
//  rs_D         out  5      instr_D[25:21]
//  rt_D         out  5      instr_D[20:16]
//  rd_D         out  5      instr_D[15:11]
//  funct_D      out  6      instr_D[5:0]
//  imm_D        out  16     instr_D[15:0]
//  j_address_D  out  26     instr_D[25:0]
//  stall_cnt    out  CNT_W  cycles with stall=1 && valid_D=1, saturating
// BEHAVIOUR
//  - All state updates on posedge clk; field outputs are pure slices of instr_D (zero added latency).
//  - Latency: pc_F/instr_F sampled at edge N appear on pc_D/instr_D after edge N (1 cycle).
//  - Priority per edge: reset > stall > flush > load.
//  - reset: pc_D=RESET_PC, instr_D=0, valid_D=0, bd_D=0, exc_D=0, stall_cnt=0.
//  - stall=1: all D registers hold; a flush asserted in the same cycle is ignored.
//    The hazard unit re-asserts flush after stall drops.
//  - stall=1 && valid_D=1: stall_cnt += 1, saturating at all-ones (no wrap). Otherwise stall_cnt holds.
//  - flush=1 (stall=0): instr_D=0, valid_D=0, bd_D=0, exc_D=0; pc_D<=pc_F (kept for EPC reporting).
//  - load (stall=0, flush=0): pc_D<=pc_F, instr_D<=instr_F, valid_D<=1, bd_D<=(jump_D && valid_D).
//    bd_D uses the old valid_D/jump_D, i.e. those of the instruction leaving D.
//  - jump_D is sampled only on load edges; it is ignored when valid_D=0.
//  - A stalled branch keeps its slot's bd_D computation pending: the slot loads on the first non-stall edge.
//  - reset asserted mid-stall or mid-flush wins unconditionally on that edge.
// CONFIGURATION
//  FD_ALIGN_CHECK_EN defined:
//    - on load, if pc_F[1:0]!=2'b00 or pc_F<PC_LO or pc_F>PC_HI: instr_D<=0, exc_D<=5'd4 (AdEL).
//      valid_D<=1, pc_D<=pc_F, bd_D computed as normal.
//    - legal pc_F loads exc_D<=0.
//  FD_ALIGN_CHECK_EN undefined:
//    - no range/alignment check; exc_D constant 0; instr_F loaded unmodified for any pc_F.
//    - PC_LO/PC_HI unused.
// TESTING
//  1 reset: assert reset 1 cycle -> pc_D=32'h3000, instr_D=0, valid_D=0, bd_D=0, stall_cnt=0.
//  2 load: pc_F=32'h3004, instr_F=32'h8C22_0010 -> next cycle pc_D=32'h3004, valid_D=1, op_D=6'h23, rs_D=1, rt_D=2, imm_D=16'h0010.
//  3 stall: hold stall 3 cycles with valid_D=1 while pc_F changes -> pc_D/instr_D unchanged, stall_cnt=3.
//    Preset stall_cnt to 16'hFFFF and stall again -> stall_cnt stays 16'hFFFF.
//  4 flush vs stall: stall=1, flush=1 -> D held; then stall=0, flush=1, pc_F=32'h3010 -> instr_D=0, valid_D=0, pc_D=32'h3010.
//  5 delay slot: D holds beq (jump_D=1, valid_D=1), load pc_F=32'h3014 -> bd_D=1.
//    Next load with jump_D=0 -> bd_D=0. Same sequence after a flush bubble -> bd_D=0.
//  6 FD_ALIGN_CHECK_EN: load pc_F=32'h3002 -> exc_D=4, instr_D=0, valid_D=1.
//    pc_F=32'h7000 -> exc_D=4. Macro undefined: pc_F=32'h3002 -> exc_D=0, instr_D=instr_F.

Source files
------------

// File: rtl/fd_reg.sv
// F->D pipeline register: stall hold, flush bubble, delay-slot flag, saturating stall counter.
// Optional fetch-address check enabled by defining FD_ALIGN_CHECK_EN.
module fd_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFC,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      pc_F,
  input  logic [31:0]      instr_F,
  input  logic             jump_D,
  output logic [31:0]      pc_D,
  output logic [31:0]      instr_D,
  output logic             valid_D,
  output logic             bd_D,
  output logic [4:0]       exc_D,
  output logic [5:0]       op_D,
  output logic [4:0]       rs_D,
  output logic [4:0]       rt_D,
  output logic [4:0]       rd_D,
  output logic [5:0]       funct_D,
  output logic [15:0]      imm_D,
  output logic [25:0]      j_address_D,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned EXC_W    = 5;
  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  // Instruction actually captured on a load edge, and its fetch exception code.
  logic [31:0]      instr_load;
  logic [EXC_W-1:0] exc_load;

`ifdef FD_ALIGN_CHECK_EN
  logic addr_bad;
  logic [EXC_W-1:0] exc_q;

  always_comb begin
    addr_bad   = (pc_F[1:0] != 2'b00) || (pc_F < PC_LO) || (pc_F > PC_HI);
    instr_load = addr_bad ? 32'h0 : instr_F;
    exc_load   = addr_bad ? EXC_ADEL : EXC_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_q <= EXC_NONE;
    end else if (!stall) begin
      exc_q <= flush ? EXC_NONE : exc_load;
    end
  end

  assign exc_D = exc_q;
`else
  always_comb begin
    instr_load = instr_F;
    exc_load   = EXC_NONE;
  end

  assign exc_D = exc_load;
`endif

  // Main D-stage registers; stall beats flush, flush beats load.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_D    <= RESET_PC;
      instr_D <= 32'h0;
      valid_D <= 1'b0;
      bd_D    <= 1'b0;
    end else if (!stall) begin
      pc_D <= pc_F;
      if (flush) begin
        instr_D <= 32'h0;
        valid_D <= 1'b0;
        bd_D    <= 1'b0;
      end else begin
        instr_D <= instr_load;
        valid_D <= 1'b1;
        bd_D    <= jump_D && valid_D;
      end
    end
  end

  // Counts stalled cycles of real instructions; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && valid_D && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign op_D        = instr_D[31:26];
  assign rs_D        = instr_D[25:21];
  assign rt_D        = instr_D[20:16];
  assign rd_D        = instr_D[15:11];
  assign funct_D     = instr_D[5:0];
  assign imm_D       = instr_D[15:0];
  assign j_address_D = instr_D[25:0];

  // Legal-fetch window must be well formed and word aligned.
  a_pc_range: assert property (@(posedge clk) disable iff (reset)
    (PC_LO <= PC_HI) && (PC_LO[1:0] == 2'b00) && (PC_HI[1:0] == 2'b00));

endmodule

// File: tb/tb_fd_reg.sv
// Self-checking bench for fd_reg: directed vectors plus a per-cycle reference model.
module tb_fd_reg;
  logic        clk = 1'b0;
  logic        reset, stall, flush, jump_D;
  logic [31:0] pc_F, instr_F;

  logic [31:0] pc_D, instr_D, pc_D4, instr_D4;
  logic        valid_D, bd_D, valid_D4, bd_D4;
  logic [4:0]  exc_D, rs_D, rt_D, rd_D, exc_D4, rs_D4, rt_D4, rd_D4;
  logic [5:0]  op_D, funct_D, op_D4, funct_D4;
  logic [15:0] imm_D, imm_D4, stall_cnt;
  logic [25:0] j_address_D, j_address_D4;
  logic [3:0]  stall_cnt4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fd_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .pc_F(pc_F),
    .instr_F(instr_F), .jump_D(jump_D), .pc_D(pc_D), .instr_D(instr_D),
    .valid_D(valid_D), .bd_D(bd_D), .exc_D(exc_D), .op_D(op_D), .rs_D(rs_D),
    .rt_D(rt_D), .rd_D(rd_D), .funct_D(funct_D), .imm_D(imm_D),
    .j_address_D(j_address_D), .stall_cnt(stall_cnt)
  );

  fd_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .pc_F(pc_F),
    .instr_F(instr_F), .jump_D(jump_D), .pc_D(pc_D4), .instr_D(instr_D4),
    .valid_D(valid_D4), .bd_D(bd_D4), .exc_D(exc_D4), .op_D(op_D4), .rs_D(rs_D4),
    .rt_D(rt_D4), .rd_D(rd_D4), .funct_D(funct_D4), .imm_D(imm_D4),
    .j_address_D(j_address_D4), .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: what D must hold, derived from the pipeline-register rules.
  bit          m_on = 0;
  logic [31:0] m_pc, m_instr;
  bit          m_valid, m_bd;
  int          m_exc, m_cnt, m_cnt4;

  function automatic bit fetch_bad(input logic [31:0] pc);
`ifdef FD_ALIGN_CHECK_EN
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_on = 1; m_pc = 32'h3000; m_instr = 0; m_valid = 0; m_bd = 0;
      m_exc = 0; m_cnt = 0; m_cnt4 = 0;
    end else if (stall) begin
      if (m_valid) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end else begin
      bit leaving_branch;
      leaving_branch = jump_D && m_valid;
      m_pc = pc_F;
      if (flush) begin
        m_instr = 0; m_valid = 0; m_bd = 0; m_exc = 0;
      end else begin
        m_instr = fetch_bad(pc_F) ? 32'h0 : instr_F;
        m_exc   = fetch_bad(pc_F) ? 4 : 0;
        m_valid = 1;
        m_bd    = leaving_branch;
      end
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (m_on) begin
      chk("pc_D", pc_D, m_pc);
      chk("instr_D", instr_D, m_instr);
      chk("valid_D", 32'(valid_D), 32'(m_valid));
      chk("bd_D", 32'(bd_D), 32'(m_bd));
      chk("exc_D", 32'(exc_D), 32'(m_exc));
      chk("op_D", 32'(op_D), m_instr / (1 << 26));
      chk("rs_D", 32'(rs_D), (m_instr / (1 << 21)) % 32);
      chk("rt_D", 32'(rt_D), (m_instr / (1 << 16)) % 32);
      chk("rd_D", 32'(rd_D), (m_instr / (1 << 11)) % 32);
      chk("funct_D", 32'(funct_D), m_instr % 64);
      chk("imm_D", 32'(imm_D), m_instr % 65536);
      chk("j_address_D", 32'(j_address_D), m_instr % (1 << 26));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      chk("stall_cnt4", 32'(stall_cnt4), 32'(m_cnt4));
      chk("pc_D4", pc_D4, m_pc);
      chk("valid_D4", 32'(valid_D4), 32'(m_valid));
    end
  end

  task automatic cyc(input logic r, input logic s, input logic f,
                     input logic [31:0] pc, input logic [31:0] ins, input logic j);
    reset = r; stall = s; flush = f; pc_F = pc; instr_F = ins; jump_D = j;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] LW  = 32'h8C22_0010;
  localparam logic [31:0] BEQ = 32'h1022_0003;

  initial begin
    reset = 1; stall = 0; flush = 0; pc_F = 0; instr_F = 0; jump_D = 0;

    // Reset state
    cyc(1, 0, 0, 32'h3008, 32'hDEAD_BEEF, 0);
    chk("rst pc_D", pc_D, 32'h3000);
    chk("rst instr_D", instr_D, 32'h0);
    chk("rst valid_D", 32'(valid_D), 32'h0);
    chk("rst bd_D", 32'(bd_D), 32'h0);
    chk("rst stall_cnt", 32'(stall_cnt), 32'h0);

    // Plain load and field slicing
    cyc(0, 0, 0, 32'h3004, LW, 0);
    chk("ld pc_D", pc_D, 32'h3004);
    chk("ld valid_D", 32'(valid_D), 32'h1);
    chk("ld op_D", 32'(op_D), 32'h23);
    chk("ld rs_D", 32'(rs_D), 32'h1);
    chk("ld rt_D", 32'(rt_D), 32'h2);
    chk("ld imm_D", 32'(imm_D), 32'h10);

    // Stall hold and counting, with the 4-bit instance reaching saturation
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'h4000 + 32'(i * 4), 32'hFFFF_0000, 0);
    chk("stl pc_D", pc_D, 32'h3004);
    chk("stl instr_D", instr_D, LW);
    chk("stl stall_cnt", 32'(stall_cnt), 32'd3);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 32'h5000, 32'h1, 0);
    chk("stl cnt 23", 32'(stall_cnt), 32'd23);
    chk("stl cnt4 sat", 32'(stall_cnt4), 32'hF);

    // Flush ignored under stall, honoured after
    cyc(0, 1, 1, 32'h300C, 32'h2, 0);
    chk("sf pc_D", pc_D, 32'h3004);
    chk("sf valid_D", 32'(valid_D), 32'h1);
    cyc(0, 0, 1, 32'h3010, 32'h3, 0);
    chk("fl instr_D", instr_D, 32'h0);
    chk("fl valid_D", 32'(valid_D), 32'h0);
    chk("fl pc_D", pc_D, 32'h3010);

    // Delay slot tracking
    cyc(0, 0, 0, 32'h3010, BEQ, 0);
    chk("beq bd_D", 32'(bd_D), 32'h0);
    cyc(0, 0, 0, 32'h3014, 32'h0, 1);
    chk("slot bd_D", 32'(bd_D), 32'h1);
    cyc(0, 0, 0, 32'h3018, 32'h2001_0005, 0);
    chk("post bd_D", 32'(bd_D), 32'h0);
    cyc(0, 0, 0, 32'h301C, BEQ, 0);
    cyc(0, 1, 0, 32'h3020, 32'h4, 1);
    cyc(0, 1, 0, 32'h3020, 32'h4, 1);
    chk("stl beq bd_D", 32'(bd_D), 32'h0);
    chk("stl cnt 26", 32'(stall_cnt), 32'd26);
    cyc(0, 0, 0, 32'h3020, 32'h4, 1);
    chk("stl slot bd_D", 32'(bd_D), 32'h1);
    cyc(0, 0, 1, 32'h3024, 32'h5, 1);
    cyc(0, 1, 0, 32'h3028, 32'h6, 1);
    cyc(0, 1, 0, 32'h3028, 32'h6, 1);
    chk("bubble stall cnt", 32'(stall_cnt), 32'd26);
    cyc(0, 0, 0, 32'h3028, 32'h6, 1);
    chk("bubble bd_D", 32'(bd_D), 32'h0);
    chk("bubble valid_D", 32'(valid_D), 32'h1);

    // Fetch address check
    cyc(0, 0, 0, 32'h3002, 32'h1234_5678, 0);
    chk("mis valid_D", 32'(valid_D), 32'h1);
`ifdef FD_ALIGN_CHECK_EN
    chk("mis exc_D", 32'(exc_D), 32'd4);
    chk("mis instr_D", instr_D, 32'h0);
    cyc(0, 0, 0, 32'h7000, 32'h1234_5678, 0);
    chk("hi exc_D", 32'(exc_D), 32'd4);
`else
    chk("mis exc_D", 32'(exc_D), 32'd0);
    chk("mis instr_D", instr_D, 32'h1234_5678);
    cyc(0, 0, 0, 32'h7000, 32'h1234_5678, 0);
    chk("hi exc_D", 32'(exc_D), 32'd0);
`endif
    cyc(0, 0, 0, 32'h6FFC, 32'hABCD_0123, 0);
    chk("edge exc_D", 32'(exc_D), 32'd0);
    chk("edge instr_D", instr_D, 32'hABCD_0123);

    // Reset wins over a simultaneous stall and flush
    cyc(0, 1, 0, 32'h3030, 32'h7, 0);
    cyc(1, 1, 1, 32'h3034, 32'h8, 1);
    chk("rst2 pc_D", pc_D, 32'h3000);
    chk("rst2 valid_D", 32'(valid_D), 32'h0);
    chk("rst2 stall_cnt", 32'(stall_cnt), 32'h0);

    // Mixed pattern, checked cycle by cycle against the model
    for (int i = 0; i < 80; i++) begin
      logic s, f, j;
      logic [31:0] pc;
      s  = (i % 5 == 2) || (i % 7 == 3);
      f  = (i % 6 == 4);
      j  = (i % 3 == 0);
      pc = 32'h3000 + 32'(i * 4) + ((i % 11 == 5) ? 32'h2 : 32'h0);
      if (i == 60) pc = 32'h2FFC;
      cyc(0, s, f, pc, 32'(i) * 32'h9E37_79B9, j);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
